// File: rtl/chunked_borrow_subtractor.sv
// Multi-cycle unsigned subtractor: D = {borrow_out, A-B}, one CHUNK-bit slice per clock,
// least-significant slice first, with valid/ready handshakes on both sides.
module chunked_borrow_subtractor #(
  parameter int ANCHO = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ANCHO:0]   D,
  output logic             busy
);
  localparam int NCHUNK = ANCHO / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (ANCHO % CHUNK != 0) begin : g_bad_chunk
    $error("chunked_borrow_subtractor: ANCHO must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [ANCHO-1:0] a_q, a_d, b_q, b_d;
  logic [ANCHO:0]   d_q, d_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [CHUNK:0]   slice_diff;

  // Operands shift right each RUN cycle so the active slice is always at bit 0;
  // the MSB of the widened difference is the borrow into the next slice.
  assign slice_diff = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
                    - {{CHUNK{1'b0}}, borrow_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        d_d[int'(idx_q)*CHUNK +: CHUNK] = slice_diff[CHUNK-1:0];
        borrow_d = slice_diff[CHUNK];
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          d_d[ANCHO] = slice_diff[CHUNK];
          idx_d      = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign D         = d_q;

endmodule

// File: tb/tb_chunked_borrow_subtractor.sv
// Self-checking bench for chunked_borrow_subtractor (ANCHO=64, CHUNK=8): directed cases
// plus randomized pairs with output stalls, checked against a {borrow, A-B} model.
module tb_chunked_borrow_subtractor;
  localparam int ANCHO  = 64;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = ANCHO / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ANCHO-1:0] A = '0;
  logic [ANCHO-1:0] B = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ANCHO:0]   D;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  chunked_borrow_subtractor #(.ANCHO(ANCHO), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .D(D), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: widened unsigned subtraction; bit ANCHO is set exactly when A < B.
  function automatic logic [ANCHO:0] ref_sub(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for in_ready, then presents one pair for exactly one accept edge.
  task automatic accept(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b, output bit ok);
    int k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    ok = in_ready;
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen; 99 on timeout.
  task automatic wait_valid(output int cycles, output bit ready_seen);
    cycles = 0;
    ready_seen = 1'b0;
    while (!out_valid && cycles < 99) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      cycles++;
    end
    if (!out_valid) cycles = 99;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    A = 64'd77;
    B = 64'd11;
    do_reset();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    n_tests++;
    if (D !== '0) begin
      n_fail++;
      $display("FAIL reset_d: D=%h want 0", D);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_directed(input string name, input logic [ANCHO-1:0] a,
                               input logic [ANCHO-1:0] b, input logic [ANCHO:0] want);
    bit ok, rdy;
    int cyc;
    out_ready = 1'b1;
    accept(a, b, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_accept: in_ready never rose", name);
    end
    wait_valid(cyc, rdy);
    n_tests++;
    if (cyc != NCHUNK) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles want %0d", name, cyc, NCHUNK);
    end
    n_tests++;
    if (rdy || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_in_run: in_ready seen high=%b in_ready=%b busy=%b", name, rdy, in_ready, busy);
    end
    n_tests++;
    if (D !== want || D !== ref_sub(a, b)) begin
      n_fail++;
      $display("FAIL %s_result: D=%h want %h", name, D, want);
    end
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_exit: in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    bit ok, rdy, bad;
    int cyc;
    logic [ANCHO:0] want;
    want = {1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    out_ready = 1'b0;
    accept(64'd5, 64'd7, ok);
    wait_valid(cyc, rdy);
    n_tests++;
    if (cyc != NCHUNK || D !== want) begin
      n_fail++;
      $display("FAIL bp_result: cycles=%0d D=%h want %0d %h", cyc, D, NCHUNK, want);
    end
    bad = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      tick();
      if (D !== want || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: D=%h out_valid=%b in_ready=%b, want %h 1 0", D, out_valid, in_ready, want);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_abort();
    bit ok, seen;
    out_ready = 1'b1;
    accept(64'd9, 64'd3, ok);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || D !== '0) begin
      n_fail++;
      $display("FAIL abort_state: in_ready=%b busy=%b out_valid=%b D=%h want 1 0 0 0",
               in_ready, busy, out_valid, D);
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * NCHUNK; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_result: out_valid rose for aborted op");
    end
    test_directed("abort_retry", 64'd9, 64'd3, 65'd6);
  endtask

  task automatic test_back_to_back();
    int k;
    bit second;
    logic [ANCHO:0] d1;
    out_ready = 1'b1;
    A = '1;
    B = '1;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    tick();
    A = 64'd1;
    B = 64'd2;
    k = 0;
    second = 1'b0;
    d1 = '1;
    while (!second && k < 40) begin
      second = in_ready;
      tick();
      k++;
      if (out_valid) d1 = D;
    end
    in_valid = 1'b0;
    n_tests++;
    if (d1 !== 65'd0) begin
      n_fail++;
      $display("FAIL b2b_first: D=%h want 0", d1);
    end
    n_tests++;
    if (k != NCHUNK + 2) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d cycles want %0d", k, NCHUNK + 2);
    end
    k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    n_tests++;
    if (!out_valid || D !== {1'b1, {ANCHO{1'b1}}}) begin
      n_fail++;
      $display("FAIL b2b_second: out_valid=%b D=%h want 1 %h", out_valid, D, {1'b1, {ANCHO{1'b1}}});
    end
    tick();
  endtask

  task automatic test_random(input int n);
    bit ok, rdy, stable;
    int cyc, bad_res, bad_hold, stalls;
    logic [ANCHO-1:0] a, b;
    logic [ANCHO:0] want;
    bad_res = 0;
    bad_hold = 0;
    for (int i = 0; i < n; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a + 64'd1;
        default: b = {$urandom, $urandom};
      endcase
      want = ref_sub(a, b);
      out_ready = 1'b0;
      accept(a, b, ok);
      wait_valid(cyc, rdy);
      if (!ok || cyc != NCHUNK || D !== want) begin
        bad_res++;
        if (bad_res <= 5)
          $display("FAIL rand_result: A=%h B=%h D=%h want %h cycles=%0d", a, b, D, want, cyc);
      end
      stable = 1'b1;
      stalls = 0;
      out_ready = ($urandom_range(0, 2) == 0);
      while (out_valid && stalls < 20) begin
        if (D !== want) stable = 1'b0;
        tick();
        stalls++;
        out_ready = ($urandom_range(0, 2) == 0) || (stalls > 10);
      end
      if (!stable || out_valid) bad_hold++;
    end
    n_tests++;
    if (bad_res != 0) begin
      n_fail++;
      $display("FAIL rand_results: %0d of %0d wrong", bad_res, n);
    end
    n_tests++;
    if (bad_hold != 0) begin
      n_fail++;
      $display("FAIL rand_hold: %0d of %0d unstable or stuck under stalls", bad_hold, n);
    end
  endtask

  initial begin
    test_reset();
    test_directed("sub_100_58", 64'd100, 64'd58, 65'h0_0000_0000_0000_002A);
    test_directed("sub_0_1", 64'd0, 64'd1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    test_directed("sub_ripple7", 64'h0100_0000_0000_0000, 64'd1, 65'h0_00FF_FFFF_FFFF_FFFF);
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random(2000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
